// File: rtl/rename_map_table.sv
// Register rename map table: per-lane source/destination translation with
// in-group forwarding, plus a circular store of branch checkpoints.
module rename_map_table #(
    parameter int WIDTH    = 2,
    parameter int NUM_AR   = 32,
    parameter int NUM_PR   = 64,
    parameter int NUM_CKPT = 4,
    localparam int PRW     = $clog2(NUM_PR),
    localparam int ARW     = $clog2(NUM_AR),
    localparam int CTW     = $clog2(NUM_CKPT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ext_stall,
    input  logic [WIDTH-1:0]          valid_instr,
    input  logic [WIDTH-1:0][ARW-1:0] rs1,
    input  logic [WIDTH-1:0][ARW-1:0] rs2,
    input  logic [WIDTH-1:0][ARW-1:0] rd,
    input  logic [WIDTH-1:0]          valid_new_rd,
    input  logic [WIDTH-1:0][PRW-1:0] phys_rd,
    input  logic [WIDTH-1:0]          if_checkpoint,
    input  logic                      recall_valid,
    input  logic [CTW-1:0]            recall_tag,
    input  logic                      free_valid,
    output logic [WIDTH-1:0][PRW-1:0] phys_rs1,
    output logic [WIDTH-1:0][PRW-1:0] phys_rs2,
    output logic [WIDTH-1:0][PRW-1:0] old_rd,
    output logic [CTW-1:0]            ckpt_tag,
    output logic                      ckpt_full,
    output logic                      int_stall
);

    localparam int CNW = $clog2(NUM_CKPT + 1);

    typedef logic [NUM_AR-1:0][PRW-1:0] map_t;

    map_t             map_q, map_d;
    map_t             ckpt_q [NUM_CKPT];
    map_t             ckpt_wdata;
    logic             ckpt_we;
    logic [CTW-1:0]   head_q, head_d;
    logic [CTW-1:0]   tail_q, tail_d;
    logic [CNW-1:0]   count_q, count_d;
    logic             ckpt_full_q;
    logic [WIDTH-1:0] lane_wr;
    logic             ckpt_req;
    logic             accept;
    logic             free_ok;

    function automatic logic [CTW-1:0] ptr_inc(input logic [CTW-1:0] p);
        return (p == CTW'(NUM_CKPT - 1)) ? '0 : p + CTW'(1);
    endfunction

    // Number of slots from 'from' up to (not including) 'to', modulo the ring size.
    function automatic logic [CNW-1:0] ptr_dist(input logic [CTW-1:0] from,
                                                 input logic [CTW-1:0] to);
        return (to >= from) ? CNW'(to - from)
                            : CNW'(NUM_CKPT) - CNW'(from) + CNW'(to);
    endfunction

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            lane_wr[j] = valid_instr[j] && valid_new_rd[j] && (rd[j] != '0);
        end
    end

    assign ckpt_req  = |(if_checkpoint & valid_instr);
    assign int_stall = recall_valid || (ckpt_req && ckpt_full_q);
    assign accept    = reset && !ext_stall && !int_stall;
    assign ckpt_tag  = tail_q;
    assign ckpt_full = ckpt_full_q;

    // Older lanes in the same group shadow the registered map; youngest older writer wins.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            phys_rs1[k] = map_q[rs1[k]];
            phys_rs2[k] = map_q[rs2[k]];
            old_rd[k]   = map_q[rd[k]];
            for (int j = 0; j < k; j++) begin
                if (lane_wr[j] && rd[j] == rs1[k]) phys_rs1[k] = phys_rd[j];
                if (lane_wr[j] && rd[j] == rs2[k]) phys_rs2[k] = phys_rd[j];
                if (lane_wr[j] && rd[j] == rd[k])  old_rd[k]   = phys_rd[j];
            end
        end
    end

    always_comb begin
        // NOTE: blocking assignments here let later lanes see earlier lanes' map writes.
        map_d      = map_q;
        ckpt_wdata = map_q;
        ckpt_we    = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        free_ok    = free_valid && (count_q != '0);
        if (accept) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (lane_wr[j]) map_d[rd[j]] = phys_rd[j];
                if (if_checkpoint[j] && valid_instr[j]) begin
                    ckpt_we    = 1'b1;
                    ckpt_wdata = map_d;
                end
            end
        end
        if (ckpt_we) tail_d = ptr_inc(tail_q);
        if (free_ok) head_d = ptr_inc(head_q);
        count_d = count_q + CNW'(ckpt_we) - CNW'(free_ok);

        // A recall discards the group's own updates; the recalled slot itself stays live.
        if (recall_valid) begin
            map_d   = ckpt_q[recall_tag];
            tail_d  = ptr_inc(recall_tag);
            count_d = ptr_dist(head_q, recall_tag) + CNW'(1);
            head_d  = head_q;
            if (free_valid) begin
                head_d  = ptr_inc(head_q);
                count_d = count_d - CNW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AR; i++) map_q[i] <= PRW'(i);
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ckpt_full_q <= 1'b0;
        end else begin
            map_q       <= map_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ckpt_full_q <= (count_d == CNW'(NUM_CKPT));
        end
    end

    // NOTE: checkpoint storage is not reset; count_q == 0 marks every slot dead.
    always_ff @(posedge clk) begin
        if (ckpt_we) ckpt_q[tail_q] <= ckpt_wdata;
    end

    recall_free_head_a : assert property (@(posedge clk) disable iff (!reset)
        !(recall_valid && free_valid && recall_tag == head_q));

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_rename_map_table;

    localparam int WIDTH    = 2;
    localparam int NUM_AR   = 32;
    localparam int NUM_PR   = 64;
    localparam int NUM_CKPT = 4;
    localparam int PRW      = $clog2(NUM_PR);
    localparam int ARW      = $clog2(NUM_AR);
    localparam int CTW      = $clog2(NUM_CKPT);

    logic                      clk;
    logic                      reset;
    logic                      ext_stall;
    logic [WIDTH-1:0]          valid_instr;
    logic [WIDTH-1:0][ARW-1:0] rs1, rs2, rd;
    logic [WIDTH-1:0]          valid_new_rd;
    logic [WIDTH-1:0][PRW-1:0] phys_rd;
    logic [WIDTH-1:0]          if_checkpoint;
    logic                      recall_valid;
    logic [CTW-1:0]            recall_tag;
    logic                      free_valid;
    logic [WIDTH-1:0][PRW-1:0] phys_rs1, phys_rs2, old_rd;
    logic [CTW-1:0]            ckpt_tag;
    logic                      ckpt_full;
    logic                      int_stall;

    int checks = 0;
    int errors = 0;

    rename_map_table #(
        .WIDTH(WIDTH), .NUM_AR(NUM_AR), .NUM_PR(NUM_PR), .NUM_CKPT(NUM_CKPT)
    ) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall),
        .valid_instr(valid_instr), .rs1(rs1), .rs2(rs2), .rd(rd),
        .valid_new_rd(valid_new_rd), .phys_rd(phys_rd),
        .if_checkpoint(if_checkpoint), .recall_valid(recall_valid),
        .recall_tag(recall_tag), .free_valid(free_valid),
        .phys_rs1(phys_rs1), .phys_rs2(phys_rs2), .old_rd(old_rd),
        .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full), .int_stall(int_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arrays and modular counters.
    int m_map [NUM_AR];
    int m_ckpt [NUM_CKPT][NUM_AR];
    int m_head, m_tail, m_count;

    logic [WIDTH-1:0][PRW-1:0] exp_rs1, exp_rs2, exp_old;
    logic [CTW-1:0]            exp_tag;
    logic                      exp_full, exp_stall;

    function automatic bit lane_writes(int j);
        return valid_instr[j] && valid_new_rd[j] && (rd[j] != 0);
    endfunction

    function automatic int fwd(int k, int r);
        for (int j = k - 1; j >= 0; j--)
            if (lane_writes(j) && int'(rd[j]) == r) return int'(phys_rd[j]);
        return m_map[r];
    endfunction

    function automatic bit any_ckpt();
        return (if_checkpoint & valid_instr) != 0;
    endfunction

    task automatic model_outputs();
        for (int k = 0; k < WIDTH; k++) begin
            exp_rs1[k] = PRW'(fwd(k, int'(rs1[k])));
            exp_rs2[k] = PRW'(fwd(k, int'(rs2[k])));
            exp_old[k] = PRW'(fwd(k, int'(rd[k])));
        end
        exp_tag   = CTW'(m_tail);
        exp_full  = (m_count == NUM_CKPT);
        exp_stall = recall_valid || (any_ckpt() && m_count == NUM_CKPT);
    endtask

    task automatic model_commit();
        int  old_count;
        bit  acc;
        if (!reset) begin
            for (int i = 0; i < NUM_AR; i++) m_map[i] = i;
            m_head = 0; m_tail = 0; m_count = 0;
            return;
        end
        if (recall_valid) begin
            m_map   = m_ckpt[recall_tag];
            m_tail  = (int'(recall_tag) + 1) % NUM_CKPT;
            m_count = (int'(recall_tag) - m_head + NUM_CKPT) % NUM_CKPT + 1;
            if (free_valid) begin
                m_head  = (m_head + 1) % NUM_CKPT;
                m_count = m_count - 1;
            end
            return;
        end
        old_count = m_count;
        acc = !ext_stall && !(any_ckpt() && m_count == NUM_CKPT);
        if (acc) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (lane_writes(j)) m_map[rd[j]] = int'(phys_rd[j]);
                if (if_checkpoint[j] && valid_instr[j]) begin
                    m_ckpt[m_tail] = m_map;
                    m_tail  = (m_tail + 1) % NUM_CKPT;
                    m_count = m_count + 1;
                end
            end
        end
        if (free_valid && old_count > 0) begin
            m_head  = (m_head + 1) % NUM_CKPT;
            m_count = m_count - 1;
        end
    endtask

    task automatic idle_inputs();
        ext_stall = 0; valid_instr = '0; valid_new_rd = '0; if_checkpoint = '0;
        rs1 = '0; rs2 = '0; rd = '0; phys_rd = '0;
        recall_valid = 0; recall_tag = '0; free_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        valid_instr = 2'b11;
        rs1[0] = 5; rs1[1] = 7; rs2[0] = 7; rs2[1] = 5; rd[0] = 3; rd[1] = 4;
        #1;
        checks++;
        if (phys_rs1 !== {6'd7, 6'd5}) begin
            errors++; $display("FAIL reset_phys_rs1 got %h expected %h", phys_rs1, {6'd7, 6'd5});
        end
        checks++;
        if ({phys_rs2, old_rd} !== {6'd5, 6'd7, 6'd4, 6'd3}) begin
            errors++; $display("FAIL reset_rs2_old_rd got %h %h", phys_rs2, old_rd);
        end
        checks++;
        if ({ckpt_full, int_stall, ckpt_tag} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got full=%b stall=%b tag=%0d expected 0 0 0",
                               ckpt_full, int_stall, ckpt_tag);
        end
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        valid_instr = 2'b11; valid_new_rd = 2'b11;
        rd[0] = 3; phys_rd[0] = 40; rs1[1] = 3; rd[1] = 3; phys_rd[1] = 41;
        #1;
        checks++;
        if (phys_rs1[1] !== 6'd40 || old_rd[1] !== 6'd40 || old_rd[0] !== 6'd3) begin
            errors++; $display("FAIL fwd_in_group got rs1=%0d old1=%0d old0=%0d expected 40 40 3",
                               phys_rs1[1], old_rd[1], old_rd[0]);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 3;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd41) begin
            errors++; $display("FAIL fwd_youngest_wins got %0d expected 41", phys_rs1[0]);
        end
        tick();
        idle_inputs();
        valid_instr = 2'b11; valid_new_rd = 2'b10;
        rd[0] = 9; phys_rd[0] = 45; rd[1] = 9; phys_rd[1] = 50; rs1[1] = 9;
        #1;
        checks++;
        if (phys_rs1[1] !== 6'd9) begin
            errors++; $display("FAIL fwd_nonwriter got %0d expected 9", phys_rs1[1]);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 9;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd50) begin
            errors++; $display("FAIL lane1_write got %0d expected 50", phys_rs1[0]);
        end
        tick();
        idle_inputs();
        valid_instr = 2'b11; valid_new_rd = 2'b01; rd[0] = 0; phys_rd[0] = 60; rs1[1] = 0;
        #1;
        checks++;
        if (phys_rs1[1] !== 6'd0) begin
            errors++; $display("FAIL r0_no_fwd got %0d expected 0", phys_rs1[1]);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 0; rs2[0] = 0;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd0 || phys_rs2[0] !== 6'd0) begin
            errors++; $display("FAIL r0_hardwired got %0d %0d expected 0 0", phys_rs1[0], phys_rs2[0]);
        end
        tick();
    endtask

    task automatic test_checkpoint_recall();
        do_reset();
        valid_instr = 2'b11; valid_new_rd = 2'b11; if_checkpoint = 2'b01;
        rd[0] = 2; phys_rd[0] = 33; rd[1] = 2; phys_rd[1] = 34;
        #1;
        checks++;
        if (ckpt_tag !== 2'd0 || int_stall !== 1'b0) begin
            errors++; $display("FAIL ckpt_alloc got tag=%0d stall=%b expected 0 0", ckpt_tag, int_stall);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 2;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd34 || ckpt_tag !== 2'd1) begin
            errors++; $display("FAIL ckpt_map_after got rs1=%0d tag=%0d expected 34 1", phys_rs1[0], ckpt_tag);
        end
        tick();
        idle_inputs(); recall_valid = 1; recall_tag = 0;
        #1;
        checks++;
        if (int_stall !== 1'b1) begin
            errors++; $display("FAIL recall_stall got %b expected 1", int_stall);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 2;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd33 || int_stall !== 1'b0 || ckpt_tag !== 2'd1 || ckpt_full !== 1'b0) begin
            errors++; $display("FAIL recall_restore got rs1=%0d stall=%b tag=%0d full=%b expected 33 0 1 0",
                               phys_rs1[0], int_stall, ckpt_tag, ckpt_full);
        end
        tick();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < NUM_CKPT; i++) begin
            idle_inputs(); valid_instr = 2'b01; valid_new_rd = 2'b01; if_checkpoint = 2'b01;
            rd[0] = ARW'(i + 1); phys_rd[0] = PRW'(20 + i);
            #1;
            checks++;
            if (ckpt_tag !== CTW'(i) || int_stall !== 1'b0) begin
                errors++; $display("FAIL fill_tag got tag=%0d stall=%b expected %0d 0", ckpt_tag, int_stall, i);
            end
            tick();
        end
        idle_inputs(); valid_instr = 2'b01; if_checkpoint = 2'b01; free_valid = 1;
        valid_new_rd = 2'b01; rd[0] = 10; phys_rd[0] = 55;
        #1;
        checks++;
        if (ckpt_full !== 1'b1 || int_stall !== 1'b1) begin
            errors++; $display("FAIL full_stall got full=%b stall=%b expected 1 1", ckpt_full, int_stall);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; if_checkpoint = 2'b01; rs1[0] = 10;
        #1;
        checks++;
        if (int_stall !== 1'b0 || ckpt_tag !== 2'd0 || ckpt_full !== 1'b0 || phys_rs1[0] !== 6'd10) begin
            errors++; $display("FAIL wrap_accept got stall=%b tag=%0d full=%b rs1=%0d expected 0 0 0 10",
                               int_stall, ckpt_tag, ckpt_full, phys_rs1[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ckpt_full !== 1'b1) begin
            errors++; $display("FAIL refull got %b expected 1", ckpt_full);
        end
        tick();
    endtask

    task automatic test_recall_free();
        do_reset();
        valid_instr = 2'b01; if_checkpoint = 2'b01;
        tick();
        idle_inputs(); free_valid = 1;
        tick();
        for (int t = 1; t < NUM_CKPT; t++) begin
            idle_inputs(); valid_instr = 2'b01; valid_new_rd = 2'b01; if_checkpoint = 2'b01;
            rd[0] = 5; phys_rd[0] = PRW'(10 + t);
            tick();
        end
        idle_inputs(); recall_valid = 1; recall_tag = 2; free_valid = 1;
        #1;
        checks++;
        if (int_stall !== 1'b1) begin
            errors++; $display("FAIL recall_free_stall got %b expected 1", int_stall);
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 5;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd12 || ckpt_tag !== 2'd3 || ckpt_full !== 1'b0) begin
            errors++; $display("FAIL recall_free_state got rs1=%0d tag=%0d full=%b expected 12 3 0",
                               phys_rs1[0], ckpt_tag, ckpt_full);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); valid_instr = 2'b10; if_checkpoint = 2'b10;
            tick();
            idle_inputs();
            #1;
            checks++;
            if (ckpt_full !== (i == 2) || ckpt_tag !== CTW'((i + 4) % NUM_CKPT)) begin
                errors++; $display("FAIL recall_free_count step %0d got full=%b tag=%0d expected %b %0d",
                                   i, ckpt_full, ckpt_tag, (i == 2), (i + 4) % NUM_CKPT);
            end
        end
    endtask

    task automatic test_ext_stall();
        do_reset();
        ext_stall = 1; valid_instr = 2'b11; valid_new_rd = 2'b11; if_checkpoint = 2'b10;
        rd[0] = 6; phys_rd[0] = 43; rd[1] = 7; phys_rd[1] = 44;
        #1;
        checks++;
        if (int_stall !== 1'b0) begin
            errors++; $display("FAIL ext_stall_int got %b expected 0", int_stall);
        end
        tick();
        idle_inputs(); valid_instr = 2'b11; rs1[0] = 6; rs1[1] = 7;
        #1;
        checks++;
        if (phys_rs1 !== {6'd7, 6'd6} || ckpt_tag !== 2'd0 || ckpt_full !== 1'b0) begin
            errors++; $display("FAIL ext_stall_hold got rs1=%h tag=%0d expected %h 0", phys_rs1, ckpt_tag, {6'd7, 6'd6});
        end
        tick();
        idle_inputs(); valid_instr = 2'b01; valid_new_rd = 2'b01; if_checkpoint = 2'b01;
        rd[0] = 6; phys_rd[0] = 43;
        tick();
        idle_inputs(); valid_instr = 2'b01; valid_new_rd = 2'b01; rd[0] = 6; phys_rd[0] = 50;
        tick();
        idle_inputs(); ext_stall = 1; recall_valid = 1; recall_tag = 0;
        tick();
        idle_inputs(); valid_instr = 2'b01; rs1[0] = 6;
        #1;
        checks++;
        if (phys_rs1[0] !== 6'd43) begin
            errors++; $display("FAIL recall_under_ext_stall got %0d expected 43", phys_rs1[0]);
        end
        tick();
    endtask

    task automatic test_reset_during_recall();
        idle_inputs(); valid_instr = 2'b01; valid_new_rd = 2'b01; rd[0] = 8; phys_rd[0] = 30;
        tick();
        idle_inputs(); reset = 0; recall_valid = 1; recall_tag = 0;
        tick();
        reset = 1;
        idle_inputs(); valid_instr = 2'b11; rs1[0] = 8; rs1[1] = 6;
        #1;
        checks++;
        if (phys_rs1 !== {6'd6, 6'd8} || ckpt_tag !== 2'd0 || ckpt_full !== 1'b0 || int_stall !== 1'b0) begin
            errors++; $display("FAIL reset_over_recall got rs1=%h tag=%0d full=%b stall=%b expected %h 0 0 0",
                               phys_rs1, ckpt_tag, ckpt_full, int_stall, {6'd6, 6'd8});
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            idle_inputs();
            reset        = ($urandom_range(99) != 0);
            ext_stall    = ($urandom_range(7) == 0);
            valid_instr  = WIDTH'($urandom);
            valid_new_rd = WIDTH'($urandom);
            for (int k = 0; k < WIDTH; k++) begin
                rs1[k]     = ($urandom_range(3) == 0) ? ARW'($urandom) : ARW'($urandom_range(7));
                rs2[k]     = ($urandom_range(3) == 0) ? ARW'($urandom) : ARW'($urandom_range(7));
                rd[k]      = ($urandom_range(3) == 0) ? ARW'($urandom) : ARW'($urandom_range(7));
                phys_rd[k] = PRW'($urandom);
            end
            if ($urandom_range(2) == 0) if_checkpoint[$urandom_range(WIDTH - 1)] = 1'b1;
            if (m_count > 0 && $urandom_range(7) == 0) begin
                recall_valid = 1;
                recall_tag   = CTW'((m_head + int'($urandom_range(m_count - 1))) % NUM_CKPT);
            end
            free_valid = ($urandom_range(3) == 0);
            if (recall_valid && int'(recall_tag) == m_head) free_valid = 0;
            #1;
            model_outputs();
            checks++;
            if ({phys_rs1, phys_rs2, old_rd} !== {exp_rs1, exp_rs2, exp_old}) begin
                errors++; $display("FAIL rand_lookup cycle %0d got %h %h %h expected %h %h %h",
                                   n, phys_rs1, phys_rs2, old_rd, exp_rs1, exp_rs2, exp_old);
            end
            checks++;
            if ({ckpt_tag, ckpt_full, int_stall} !== {exp_tag, exp_full, exp_stall}) begin
                errors++; $display("FAIL rand_ctrl cycle %0d got tag=%0d full=%b stall=%b expected %0d %b %b",
                                   n, ckpt_tag, ckpt_full, int_stall, exp_tag, exp_full, exp_stall);
            end
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_checkpoint_recall();
        test_full_wrap();
        test_recall_free();
        test_ext_stall();
        test_reset_during_recall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Parametrised register rename map table for the rename stage of the superscalar core. Translates architectural sources/destinations of up to `WIDTH` instructions per cycle into physical tags with in-group dependency forwarding, and owns a circular store of `NUM_CKPT` branch checkpoints. Checkpoints are allocated in program order, freed oldest-first on correct branch resolution, and restored by tag on misprediction. It sits between decode and the free list / ROB / issue queues.

## Interface
- `WIDTH`, 2, instructions renamed per cycle (≥1)
- `NUM_AR`, 32, architectural registers; register 0 is hardwired and never remapped
- `NUM_PR`, `` `NUM_PR ``, physical registers; `PRW = $clog2(NUM_PR)`, `ARW = $clog2(NUM_AR)`
- `NUM_CKPT`, 4, checkpoint slots; `CTW = $clog2(NUM_CKPT)`
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low; state resets on a rising `clk` while `reset`==0
- `ext_stall`  in  1  downstream stall; blocks all map and checkpoint updates
- `valid_instr[WIDTH]`  in  1  lane holds an instruction; lane 0 is oldest
- `rs1[WIDTH]`, `rs2[WIDTH]`, `rd[WIDTH]`  in  ARW  architectural operands
- `valid_new_rd[WIDTH]`  in  1  lane writes `rd`
- `phys_rd[WIDTH]`  in  PRW  newly allocated physical destination per lane
- `if_checkpoint[WIDTH]`  in  1  lane is a branch needing a checkpoint; at most one bit set per cycle
- `recall_valid`  in  1  misprediction; restore checkpoint `recall_tag`
- `recall_tag`  in  CTW  slot to restore
- `free_valid`  in  1  oldest checkpointed branch resolved correctly
- `phys_rs1[WIDTH]`, `phys_rs2[WIDTH]`, `old_rd[WIDTH]`  out  PRW  translated sources; previous mapping of `rd` for ROB
- `ckpt_tag`  out  CTW  slot allocated for the checkpointing lane this cycle (= tail)
- `ckpt_full`  out  1  registered; all slots in use
- `int_stall`  out  1  rename must hold the current group this cycle

## Operation
- State: `map[NUM_AR]` of PRW, `ckpt[NUM_CKPT][NUM_AR]`, `head`, `tail` (CTW, wrap modulo `NUM_CKPT`), `count` (0..NUM_CKPT).
- Reset: `map[i]=i`, head=tail=count=0; hence `phys_rs1[k]=rs1[k]`, `old_rd[k]=rd[k]`, `ckpt_full`=0, `int_stall`=0, `ckpt_tag`=0.
- Lane write `w[j] = valid_instr[j] && valid_new_rd[j] && rd[j]!=0`.
- Lookup for lane k, register r: `phys_rd[j]` of the highest j<k with `w[j]` and `rd[j]==r`; otherwise `map[r]`. Applies to `phys_rs1`, `phys_rs2`, `old_rd`. Register 0 always yields `map[0]`=0.
- `int_stall = recall_valid || (|(if_checkpoint & valid_instr) && ckpt_full)`.
- `accept = reset && !ext_stall && !int_stall`. Only accepted groups update state.
- Map update on accept: for every r, youngest lane j with `w[j]` and `rd[j]==r` writes `map[r] <= phys_rd[j]`. Each lane writes its own `phys_rd`.
- Checkpoint on accept with `if_checkpoint[c] && valid_instr[c]`: `ckpt[tail]` <= map as seen after applying lanes 0..c only (lanes >c excluded); tail++, count++.
- Free: `free_valid` with count>0 → head++, count--. `free_valid` with count==0 is ignored.
- Recall, highest priority: `map <= ckpt[recall_tag]`; tail <= recall_tag+1; count <= (recall_tag − head mod NUM_CKPT)+1; the recalled slot and all younger slots are released, the recalled slot is excepted, it stays live until freed. Checkpoint and map updates of the current group are dropped.
- Simultaneous free and recall: legal when `recall_tag != head`; head advances and count is reduced by one more. When `recall_tag == head`, the combination is illegal; a simulation assertion flags it.
- `ckpt_full` = (count==NUM_CKPT). A free in the same cycle does not unblock an allocation.

## Timing
- Lookups are combinational from registered map and current inputs: zero latency.
- Map writes, checkpoint capture, and pointer moves take effect at the next rising edge.
- A recall asserts `int_stall` for exactly its own cycle. The restored map drives outputs from the next cycle.
- `ext_stall` does not block recall or free.
- A reset asserted mid-operation discards all checkpoints and overrides recall and free.

## Test plan
- Reset, then lanes with rs1={5,7}, rd={3,4}, no writes → phys_rs1={5,7}, old_rd={3,4}.
- Lane0 rd=3→PR40, lane1 rs1=3, rd=3→PR41 → lane1 phys_rs1=40, old_rd=40; next cycle map[3]=41. Lane1 alone writing rd=9→PR50 → map[9]=50. A write to rd=0 leaves map[0]=0.
- Checkpoint on lane0 with lane0 rd=2→PR33 and lane1 rd=2→PR34 → ckpt_tag=0; ckpt[0][2]=33, map[2]=34. Recall tag 0 → one int_stall cycle, then phys_rs1 for r2 = 33 and count=1.
- Fill 4 slots, then request another checkpoint → ckpt_full=1, int_stall=1, no update. Assert free_valid in the same cycle → still stalled; next cycle accepted with ckpt_tag=0 (wrap).
- Checkpoints at tags 1, 2, 3 with head=1; recall 2 with free in the same cycle → head=2, tail=3, count=1.
- Assert ext_stall with valid writes and checkpoint → map and count unchanged. Assert reset=0 during a recall → map returns to identity, count=0.
